// File: rtl/avr_decoder_pkg.sv
// avr_decoder_pkg: shared ALU function codes, FSM states and decoded-field bundle
package avr_decoder_pkg;
   localparam logic [2:0] ALUFN_PASSB = 3'd0;
   localparam logic [2:0] ALUFN_AND   = 3'd1;
   localparam logic [2:0] ALUFN_OR    = 3'd2;
   localparam logic [2:0] ALUFN_EOR   = 3'd3;
   localparam logic [2:0] ALUFN_ADD   = 3'd4;
   localparam logic [2:0] ALUFN_SUB   = 3'd5;
   typedef enum logic {S_FIRST, S_SECOND} state_t;
   typedef struct packed {
      logic       we;
      logic [2:0] alu;
      logic       rdmux;
      logic       bmux;
      logic       mem_rd;
      logic       mem_wr;
      logic       illegal;
      logic [4:0] rd;
      logic [4:0] rr;
      logic [7:0] imm;
   } dec_t;
endpackage

// File: rtl/avr_decoder_decode_table.sv
// avr_decoder_decode_table: first-word lookup; LDS/STS recognised only with AVR_DECODER_LDS_STS_EN
module avr_decoder_decode_table
   import avr_decoder_pkg::*;
(
   input  logic [15:0] instr,
   output dec_t        d,
   output logic        two_word
);
   // map one instruction word to its control fields; anything unlisted is illegal
   always_comb begin
      d = '0;
      two_word = 1'b0;
      if (instr == 16'h0000) begin
         d = '0;
      end else if (instr[15:12] == 4'hE) begin
         d.we = 1'b1;
         d.alu = ALUFN_PASSB;
         d.rdmux = 1'b1;
         d.bmux = 1'b1;
         d.rd = {1'b1, instr[7:4]};
         d.imm = {instr[11:8], instr[3:0]};
      end else if (instr[15:12] == 4'b0010 || instr[15:10] == 6'b000011 || instr[15:10] == 6'b000110) begin
         d.we = 1'b1;
         d.rd = instr[8:4];
         d.rr = {instr[9], instr[3:0]};
         d.alu = instr[15:10] == 6'b000011 ? ALUFN_ADD :
                 instr[15:10] == 6'b000110 ? ALUFN_SUB :
                 instr[11:10] == 2'b00     ? ALUFN_AND :
                 instr[11:10] == 2'b01     ? ALUFN_EOR :
                 instr[11:10] == 2'b10     ? ALUFN_OR  : ALUFN_PASSB;
      end
`ifdef AVR_DECODER_LDS_STS_EN
      else if (instr[15:10] == 6'b100100 && instr[3:0] == 4'h0) begin
         d.we = !instr[9];
         d.mem_rd = !instr[9];
         d.mem_wr = instr[9];
         d.rd = instr[8:4];
         two_word = 1'b1;
      end
`endif
      else begin
         d.illegal = 1'b1;
      end
   end
endmodule

// File: rtl/avr_decoder.sv
// avr_decoder: AVR instruction decoder with one-deep output slot; AVR_DECODER_LDS_STS_EN enables two-word LDS/STS
module avr_decoder
   import avr_decoder_pkg::*;
#(
   parameter int ALUOP_W = 3,
   parameter int DADDR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [15:0]        instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic               flush,
   output logic               ctrl_valid,
   input  logic               ctrl_ready,
   output logic               we_ctrl,
   output logic [ALUOP_W-1:0] alu_ctrl,
   output logic               rdmux_ctrl,
   output logic               bmux_ctrl,
   output logic               mem_rd,
   output logic               mem_wr,
   output logic               illegal,
   output logic [4:0]         rd_addr,
   output logic [4:0]         rr_addr,
   output logic [7:0]         imm,
   output logic [DADDR_W-1:0] daddr
);
   state_t state, state_nxt;
   dec_t d, lat, slot, sel;
   logic two_word, accept, load;
   avr_decoder_decode_table u_decode_table (.instr(instr), .d(d), .two_word(two_word));
   assign instr_ready = !reset && !flush && (state == S_SECOND || !ctrl_valid || ctrl_ready);
   assign accept = instr_valid && instr_ready;
   assign load = accept && (state == S_SECOND || !two_word);
   assign sel = state == S_SECOND ? lat : d;
   // next state: a two-word first word moves to S_SECOND, the next accepted word returns
   always_comb begin
      state_nxt = state;
      state_nxt = flush   ? S_FIRST :
                  !accept ? state   :
                  (state == S_FIRST && two_word) ? S_SECOND : S_FIRST;
   end
   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FIRST;
      else state <= state_nxt;
   end
   // hold the first word of a two-word instruction until its address word arrives
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lat <= '0;
      else if (flush) lat <= '0;
      else if (accept && state == S_FIRST && two_word) lat <= d;
   end
   // output slot: load on completion, drain on ctrl_ready, held while stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_valid <= 1'b0;
         slot <= '0;
      end else begin
         ctrl_valid <= flush ? 1'b0 : load ? 1'b1 : ctrl_ready ? 1'b0 : ctrl_valid;
         if (load) slot <= sel;
      end
   end
`ifdef AVR_DECODER_LDS_STS_EN
   logic [DADDR_W-1:0] daddr_q;
   // data address comes from the second word; single-word instructions carry zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) daddr_q <= '0;
      else if (load) daddr_q <= state == S_SECOND ? instr[DADDR_W-1:0] : '0;
   end
   assign daddr = daddr_q;
`else
   assign daddr = '0;
`endif
   assign we_ctrl = slot.we;
   assign alu_ctrl = ALUOP_W'(slot.alu);
   assign rdmux_ctrl = slot.rdmux;
   assign bmux_ctrl = slot.bmux;
   assign mem_rd = slot.mem_rd;
   assign mem_wr = slot.mem_wr;
   assign illegal = slot.illegal;
   assign rd_addr = slot.rd;
   assign rr_addr = slot.rr;
   assign imm = slot.imm;
endmodule

// File: tb/tb_avr_decoder.sv
// tb_avr_decoder: directed and random stimulus against a transaction-level reference model
module tb_avr_decoder;
   localparam int AW = 3;
   localparam int DW = 16;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] instr = '0;
   logic instr_valid = 1'b0, flush = 1'b0, ctrl_ready = 1'b0;
   logic instr_ready, ctrl_valid, we_ctrl, rdmux_ctrl, bmux_ctrl, mem_rd, mem_wr, illegal;
   logic [AW-1:0] alu_ctrl;
   logic [4:0] rd_addr, rr_addr;
   logic [7:0] imm;
   logic [DW-1:0] daddr;
   int checks = 0;
   int errors = 0;
   logic m_valid = 1'b0, m_second = 1'b0;
   logic [15:0] m_first = '0;
   logic [42:0] m_exp = '0;
   logic [42:0] obs;

   avr_decoder #(.ALUOP_W(AW), .DADDR_W(DW)) dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .flush(flush), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .we_ctrl(we_ctrl),
      .alu_ctrl(alu_ctrl), .rdmux_ctrl(rdmux_ctrl), .bmux_ctrl(bmux_ctrl), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .illegal(illegal), .rd_addr(rd_addr), .rr_addr(rr_addr), .imm(imm), .daddr(daddr));

   always #5 clk = ~clk;
   assign obs = {we_ctrl, alu_ctrl, rdmux_ctrl, bmux_ctrl, mem_rd, mem_wr, illegal, rd_addr, rr_addr, imm, daddr};

   function automatic logic [42:0] mk(logic we, logic [2:0] alu, logic rdm, logic bm, logic mr, logic mw,
                                      logic il, logic [4:0] rd, logic [4:0] rr, logic [7:0] k, logic [15:0] da);
      return {we, alu, rdm, bm, mr, mw, il, rd, rr, k, da};
   endfunction

   function automatic logic [42:0] ref_dec(logic [15:0] w);
      casez (w)
         16'h0000:             return '0;
         16'b1110????????????: return mk(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {1'b1, w[7:4]}, '0, {w[11:8], w[3:0]}, '0);
         16'b001000??????????: return mk(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w[8:4], {w[9], w[3:0]}, '0, '0);
         16'b001001??????????: return mk(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w[8:4], {w[9], w[3:0]}, '0, '0);
         16'b001010??????????: return mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w[8:4], {w[9], w[3:0]}, '0, '0);
         16'b001011??????????: return mk(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w[8:4], {w[9], w[3:0]}, '0, '0);
         16'b000011??????????: return mk(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w[8:4], {w[9], w[3:0]}, '0, '0);
         16'b000110??????????: return mk(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w[8:4], {w[9], w[3:0]}, '0, '0);
         default:              return mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
      endcase
   endfunction

   function automatic logic is_two(logic [15:0] w);
`ifdef AVR_DECODER_LDS_STS_EN
      return w[15:10] == 6'b100100 && w[3:0] == 4'h0;
`else
      return w[15:0] == 16'hFFFF && 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic step(input logic [15:0] w, input logic v, input logic r, input logic f);
      logic er;
      instr = w;
      instr_valid = v;
      ctrl_ready = r;
      flush = f;
      #1;
      er = !f && (m_second || !m_valid || r);
      chk("instr_ready", 64'(instr_ready), 64'(er));
      @(posedge clk);
      if (f) begin
         m_valid = 1'b0;
         m_second = 1'b0;
      end else begin
         if (m_valid && r) m_valid = 1'b0;
         if (v && er) begin
            if (m_second) begin
               m_exp = mk(!m_first[9], 3'd0, 1'b0, 1'b0, !m_first[9], m_first[9], 1'b0, m_first[8:4], '0, '0, w);
               m_valid = 1'b1;
               m_second = 1'b0;
            end else if (is_two(w)) begin
               m_first = w;
               m_second = 1'b1;
            end else begin
               m_exp = ref_dec(w);
               m_valid = 1'b1;
            end
         end
      end
      #1;
      chk("ctrl_valid", 64'(ctrl_valid), 64'(m_valid));
      if (m_valid) chk("fields", 64'(obs), 64'(m_exp));
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      instr_valid = 1'b0;
      flush = 1'b0;
      #1;
      m_valid = 1'b0;
      m_second = 1'b0;
      chk("rst_ready", 64'(instr_ready), 64'd0);
      chk("rst_valid", 64'(ctrl_valid), 64'd0);
      chk("rst_fields", 64'(obs), 64'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] rnd;
      logic [15:0] w;
      @(negedge clk);
      pulse_reset();
      step(16'hEA05, 1'b1, 1'b1, 1'b0);
      step(16'h2012, 1'b1, 1'b1, 1'b0);
      step(16'hFFFF, 1'b1, 1'b1, 1'b0);
      step(16'h0000, 1'b1, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1, 1'b0);
      step(16'h9050, 1'b1, 1'b1, 1'b0);
      step(16'h1234, 1'b1, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1, 1'b0);
      step(16'h0C3F, 1'b1, 1'b0, 1'b0);
      step(16'h2C01, 1'b1, 1'b0, 1'b0);
      step(16'h2C01, 1'b1, 1'b0, 1'b0);
      step(16'h2C01, 1'b1, 1'b0, 1'b0);
      step(16'h2C01, 1'b1, 1'b1, 1'b0);
      step(16'h1B45, 1'b1, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1, 1'b0);
      step(16'h9250, 1'b1, 1'b1, 1'b0);
      step(16'hABCD, 1'b1, 1'b1, 1'b1);
      step(16'hEA05, 1'b1, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1, 1'b0);
      step(16'h9250, 1'b1, 1'b1, 1'b0);
      pulse_reset();
      step(16'hEA05, 1'b1, 1'b1, 1'b0);
      step(16'h0000, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 600; i++) begin
         rnd = $urandom;
         case (rnd[18:16])
            3'd0: w = {4'hE, rnd[11:0]};
            3'd1: w = {4'b0010, rnd[11:0]};
            3'd2: w = {6'b000011, rnd[9:0]};
            3'd3: w = {6'b000110, rnd[9:0]};
            3'd4: w = 16'h0000;
            3'd5, 3'd6: w = {6'b100100, rnd[9:4], 4'h0};
            default: w = rnd[15:0];
         endcase
         step(w, rnd[21:20] != 2'b00, rnd[23:22] != 2'b00, rnd[27:24] == 4'h0);
         if (i == 300) pulse_reset();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
